// File: rtl/nco_pkg.sv
// Shared definitions for the quarter-wave NCO.
//   - Default widths for the phase path, LUT address and output samples.
//   - Quadrant type and the per-quadrant mirror/negate rule.
//   - Constant function that computes one quarter-wave table entry.
//     It uses integer fixed-point arithmetic and runs at elaboration.
package nco_pkg;

  localparam int PHASE_W    = 32;
  localparam int LUT_ADDR_W = 8;
  localparam int SAMPLE_W   = 12;

  typedef logic [1:0] quad_t;

  // Folding rule for one quadrant:
  //   mirror - read the table backwards (~idx).
  //   negate - the sample is the negated magnitude.
  typedef struct packed {
    logic negate;
    logic mirror;
  } qtr_rule_t;

  localparam qtr_rule_t QTR_SIN_Q0 = '{negate: 1'b0, mirror: 1'b0};
  localparam qtr_rule_t QTR_SIN_Q1 = '{negate: 1'b0, mirror: 1'b1};
  localparam qtr_rule_t QTR_SIN_Q2 = '{negate: 1'b1, mirror: 1'b0};
  localparam qtr_rule_t QTR_SIN_Q3 = '{negate: 1'b1, mirror: 1'b1};

  function automatic qtr_rule_t qtr_rule(input quad_t q);
    case (q)
      2'd0:    return QTR_SIN_Q0;
      2'd1:    return QTR_SIN_Q1;
      2'd2:    return QTR_SIN_Q2;
      default: return QTR_SIN_Q3;
    endcase
  endfunction

  // pi scaled by 2^30, rounded.
  localparam longint PI_Q30 = 64'sd3373259426;

  // Computes round((2^mag_w - 1) * sin(pi*(2*idx+1) / 2^(addr_w+2))).
  // The angle is always in [0, pi/2). The Taylor series is evaluated in
  // Q30 fixed point. Twelve terms leave an error far below one LSB.
  function automatic int qsin_mag(input int addr_w, input int mag_w, input int idx);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint amp;
    x    = (PI_Q30 * longint'(2 * idx + 1)) >>> (addr_w + 2);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int k = 1; k <= 12; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    amp = (longint'(1) <<< mag_w) - 1;
    return int'((amp * sum + (longint'(1) <<< 29)) >>> 30);
  endfunction

endpackage

// File: rtl/nco_qrom.sv
// Synchronous quarter-wave sine ROM holding unsigned magnitudes.
// There are 2^ADDR_WIDTH entries.
// Entry i is round((2^MAG_WIDTH-1) * sin(2*pi*(i+0.5)/2^(ADDR_WIDTH+2))).
// The half-sample offset makes the mirrored read (~idx) exact.
//
// The table is computed from that closed form at elaboration, so the build
// never depends on an external image. INIT_FILE names the equivalent hex
// image kept alongside for downstream tools, and it must not be empty.
//
// Ports:
//   clk, rst_n      - clock and synchronous active-low reset (clears read data)
//   addr_a / data_a - read port A, one cycle latency
//   addr_b / data_b - read port B, present only with NCO_QLUT_COS_EN defined
module nco_qrom
  import nco_pkg::*;
#(
  parameter int    ADDR_WIDTH = LUT_ADDR_W,
  parameter int    MAG_WIDTH  = SAMPLE_W - 1,
  parameter string INIT_FILE  = "qsine256.hex"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  output logic [MAG_WIDTH-1:0]  data_a
`ifdef NCO_QLUT_COS_EN
  ,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic [MAG_WIDTH-1:0]  data_b
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [MAG_WIDTH-1:0] rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam int MAG = qsin_mag(ADDR_WIDTH, MAG_WIDTH, g);
    assign rom[g] = MAG_WIDTH'(MAG);
  end

  if (INIT_FILE == "") begin : g_init_chk
    $error("nco_qrom: INIT_FILE must name the quarter-wave table image");
  end

  always_ff @(posedge clk) begin
    if (!rst_n) data_a <= '0;
    else        data_a <= rom[addr_a];
  end

`ifdef NCO_QLUT_COS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) data_b <= '0;
    else        data_b <= rom[addr_b];
  end
`endif

endmodule

// File: rtl/nco_quarter_lut.sv
// Numerically controlled oscillator with a quarter-wave sine LUT.
// Quadrant folding lets a 2^ADDR_WIDTH-entry table resolve a full
// 2^(ADDR_WIDTH+2)-point period.
//
// Pipeline (free-running, no stall; the valid bit travels with the sample):
//   acc : phase accumulator, advanced by fcw_reg when en=1
//         (sync_clr has priority)
//   S1  : p1 = acc + phase_off, v1 = en
//   S2  : quadrant fold to a ROM address; registered ROM read
//   S3  : apply sign, update outputs only when the sample is valid
// The acc value present after edge t reaches sin_out at edge t+3.
//
// Optional feature: macro NCO_QLUT_COS_EN adds the cosine path.
// Without it, cos_out is tied to 0.
//
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   en          - advance accumulator and tag the sample valid
//   sync_clr    - zero the accumulator
//   fcw         - frequency control word
//   fcw_load    - latch fcw
//   phase_off   - phase offset, sampled every cycle
//   out_valid   - sin_out/cos_out carry a new sample
//   sin_out     - signed sine sample
//   cos_out     - signed cosine sample
module nco_quarter_lut
  import nco_pkg::*;
#(
  parameter int    PHASE_WIDTH = PHASE_W,
  parameter int    ADDR_WIDTH  = LUT_ADDR_W,
  parameter int    DATA_WIDTH  = SAMPLE_W,
  parameter string INIT_FILE   = "qsine256.hex"
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         sync_clr,
  input  logic [PHASE_WIDTH-1:0]       fcw,
  input  logic                         fcw_load,
  input  logic [PHASE_WIDTH-1:0]       phase_off,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] sin_out,
  output logic signed [DATA_WIDTH-1:0] cos_out
);

  localparam int MAG_W = DATA_WIDTH - 1;

  logic [PHASE_WIDTH-1:0] fcw_reg;
  logic [PHASE_WIDTH-1:0] acc;
  logic [PHASE_WIDTH-1:0] p1;
  logic                   v1;
  logic                   v2;
  logic                   sin_neg2;

  quad_t                  sin_q;
  qtr_rule_t              sin_rule;
  logic [ADDR_WIDTH-1:0]  idx;
  logic [ADDR_WIDTH-1:0]  sin_addr;
  logic [MAG_W-1:0]       sin_mag;
  logic [DATA_WIDTH-1:0]  sin_ext;

  // Phase bits below the table index are truncated, with no rounding.
  logic unused_phase_lsbs;
  assign unused_phase_lsbs = ^p1[PHASE_WIDTH-ADDR_WIDTH-3:0];

  assign sin_q    = p1[PHASE_WIDTH-1 -: 2];
  assign idx      = p1[PHASE_WIDTH-3 -: ADDR_WIDTH];
  assign sin_rule = qtr_rule(sin_q);
  assign sin_addr = sin_rule.mirror ? ~idx : idx;
  assign sin_ext  = {1'b0, sin_mag};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fcw_reg   <= '0;
      acc       <= '0;
      p1        <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      sin_neg2  <= 1'b0;
      out_valid <= 1'b0;
      sin_out   <= '0;
    end else begin
      // A same-edge increment still uses the old fcw_reg.
      if (fcw_load) fcw_reg <= fcw;
      if (sync_clr)  acc <= '0;
      else if (en)   acc <= acc + fcw_reg;
      p1        <= acc + phase_off;
      v1        <= en;
      v2        <= v1;
      sin_neg2  <= sin_rule.negate;
      out_valid <= v2;
      // The magnitude is at most 2^MAG_W-1, so negation cannot overflow.
      if (v2) sin_out <= sin_neg2 ? -sin_ext : sin_ext;
    end
  end

`ifdef NCO_QLUT_COS_EN
  // Cosine is sine one quadrant ahead.
  quad_t                 cos_q;
  qtr_rule_t             cos_rule;
  logic [ADDR_WIDTH-1:0] cos_addr;
  logic [MAG_W-1:0]      cos_mag;
  logic [DATA_WIDTH-1:0] cos_ext;
  logic                  cos_neg2;

  assign cos_q    = sin_q + 2'd1;
  assign cos_rule = qtr_rule(cos_q);
  assign cos_addr = cos_rule.mirror ? ~idx : idx;
  assign cos_ext  = {1'b0, cos_mag};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cos_neg2 <= 1'b0;
      cos_out  <= '0;
    end else begin
      cos_neg2 <= cos_rule.negate;
      if (v2) cos_out <= cos_neg2 ? -cos_ext : cos_ext;
    end
  end

  nco_qrom #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAG_WIDTH  (MAG_W),
    .INIT_FILE  (INIT_FILE)
  ) u_qrom (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr_a (sin_addr),
    .data_a (sin_mag),
    .addr_b (cos_addr),
    .data_b (cos_mag)
  );
`else
  assign cos_out = '0;

  nco_qrom #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAG_WIDTH  (MAG_W),
    .INIT_FILE  (INIT_FILE)
  ) u_qrom (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr_a (sin_addr),
    .data_a (sin_mag)
  );
`endif

endmodule

// File: tb/tb_nco_quarter_lut.sv
// Self-checking bench for nco_quarter_lut (PHASE=32, ADDR=8, DATA=12).
// A reference model of fcw_reg/acc pushes the expected samples into
// exp_q whenever an enabled edge is driven. The entry is tagged with the
// edge at which it must leave the DUT. The expected waveform comes from a
// full-period table built with real-valued $sin, with no quadrant folding.
// A negedge monitor pops and compares samples and checks the reset and
// hold behaviour. Scenario tasks add inline checks against fixed constants.
module tb_nco_quarter_lut;

  localparam int PW = 32;
  localparam int AW = 8;
  localparam int DW = 12;
  localparam int EW = 32 + 2 * DW;
  localparam int NPT = 1 << (AW + 2);
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 en;
  logic                 sync_clr;
  logic [PW-1:0]        fcw;
  logic                 fcw_load;
  logic [PW-1:0]        phase_off;
  logic                 out_valid;
  logic signed [DW-1:0] sin_out;
  logic signed [DW-1:0] cos_out;

  nco_quarter_lut #(
    .PHASE_WIDTH (PW),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .INIT_FILE   ("qsine256.hex")
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sync_clr  (sync_clr),
    .fcw       (fcw),
    .fcw_load  (fcw_load),
    .phase_off (phase_off),
    .out_valid (out_valid),
    .sin_out   (sin_out),
    .cos_out   (cos_out)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  logic rst_edge = 1'b1;
  logic [EW-1:0] exp_q[$];
  logic [PW-1:0] fcw_m;
  logic [PW-1:0] acc_m;
  int sin_tab[NPT];
  logic [DW-1:0] last_sin;
  logic [DW-1:0] last_cos;

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(-x + 0.5);
  endfunction

  function automatic logic [DW-1:0] ref_sin(input logic [PW-1:0] ph);
    logic [AW+1:0] k;
    k = ph[PW-1 -: AW+2];
    return DW'(sin_tab[k]);
  endfunction

  function automatic logic [DW-1:0] ref_cos(input logic [PW-1:0] ph);
`ifdef NCO_QLUT_COS_EN
    logic [AW+1:0] k;
    k = ph[PW-1 -: AW+2] + (AW+2)'(1 << AW);
    return DW'(sin_tab[k]);
`else
    return ph[0] & 1'b0 ? '1 : '0;
`endif
  endfunction

  // One clock: update the model at the posedge, return at the next negedge.
  task automatic step();
    logic [PW-1:0] ph;
    @(posedge clk);
    edge_n++;
    rst_edge = !rst_n;
    if (!rst_n) begin
      fcw_m = '0;
      acc_m = '0;
      exp_q.delete();
    end else begin
      if (en) begin
        ph = acc_m + phase_off;
        exp_q.push_back({32'(edge_n + 2), ref_sin(ph), ref_cos(ph)});
      end
      if (sync_clr) acc_m = '0;
      else if (en)  acc_m = acc_m + fcw_m;
      if (fcw_load) fcw_m = fcw;
    end
    @(negedge clk);
  endtask

  // Scoreboard and hold/reset monitor.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_edge) begin
      n_checks++;
      if (out_valid !== 1'b0 || sin_out !== '0 || cos_out !== '0) begin
        n_fail++;
        $display("FAIL reset_state: valid=%b sin=%0d cos=%0d, required 0/0/0",
                 out_valid, sin_out, cos_out);
      end
    end else if (out_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: edge %0d sin=%0d, no sample expected", edge_n, sin_out);
      end else begin
        e = exp_q.pop_front();
        if (int'(e[EW-1 -: 32]) != edge_n) begin
          n_fail++;
          $display("FAIL latency: sample at edge %0d, required edge %0d", edge_n, e[EW-1 -: 32]);
        end
        n_checks++;
        if (sin_out !== e[2*DW-1 -: DW]) begin
          n_fail++;
          $display("FAIL sin_sample: edge %0d got %0d, required %0d",
                   edge_n, sin_out, $signed(e[2*DW-1 -: DW]));
        end
        n_checks++;
        if (cos_out !== e[DW-1:0]) begin
          n_fail++;
          $display("FAIL cos_sample: edge %0d got %0d, required %0d",
                   edge_n, cos_out, $signed(e[DW-1:0]));
        end
      end
    end else begin
      n_checks++;
      if (sin_out !== last_sin || cos_out !== last_cos) begin
        n_fail++;
        $display("FAIL hold: sin=%0d cos=%0d, required %0d %0d",
                 sin_out, cos_out, $signed(last_sin), $signed(last_cos));
      end
      if (exp_q.size() != 0 && int'(exp_q[0][EW-1 -: 32]) <= edge_n) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_sample: none at edge %0d, required by edge %0d",
                 edge_n, exp_q[0][EW-1 -: 32]);
        void'(exp_q.pop_front());
      end
    end
    last_sin = sin_out;
    last_cos = cos_out;
  end

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; sync_clr = 1'b0; fcw = 32'h1234_5678;
    fcw_load = 1'b1; phase_off = 32'h4000_0000;
    repeat (2) step();
    n_checks++;
    if (out_valid !== 1'b0 || sin_out !== '0 || cos_out !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b sin=%0d cos=%0d, required 0/0/0",
               out_valid, sin_out, cos_out);
    end
    // With fcw_reg and acc both zero, the first sample must be phase 0.
    rst_n = 1'b1; fcw_load = 1'b0; phase_off = '0; en = 1'b1;
    repeat (3) step();
    en = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || sin_out !== 12'sd6) begin
      n_fail++;
      $display("FAIL reset_acc_zero: valid=%b sin=%0d, required 1 and 6", out_valid, sin_out);
    end
    repeat (3) step();
  endtask

  // Clear acc, load fcw, then run enabled and check the constant sequences.
  task automatic run_sequence(input string name, input logic [PW-1:0] f,
                              input int s0, input int s1, input int s2, input int s3,
                              input int c0, input int c1, input int c2, input int c3);
    int sseq[4];
    int cseq[4];
    int k;
    sseq = '{s0, s1, s2, s3};
    cseq = '{c0, c1, c2, c3};
    fcw = f; fcw_load = 1'b1; sync_clr = 1'b1; en = 1'b0; phase_off = '0;
    step();
    fcw_load = 1'b0; sync_clr = 1'b0; en = 1'b1;
    k = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      n_checks++;
      if (out_valid !== (i >= 3)) begin
        n_fail++;
        $display("FAIL %s_valid_timing: step %0d valid=%b, required %b", name, i, out_valid, i >= 3);
      end
      if (out_valid === 1'b1) begin
        n_checks++;
        if (sin_out !== DW'(sseq[k % 4])) begin
          n_fail++;
          $display("FAIL %s_sin: sample %0d got %0d, required %0d", name, k, sin_out, sseq[k % 4]);
        end
`ifdef NCO_QLUT_COS_EN
        n_checks++;
        if (cos_out !== DW'(cseq[k % 4])) begin
          n_fail++;
          $display("FAIL %s_cos: sample %0d got %0d, required %0d", name, k, cos_out, cseq[k % 4]);
        end
`else
        n_checks++;
        if (cos_out !== '0) begin
          n_fail++;
          $display("FAIL %s_cos_tied: got %0d, required 0 (cseq %0d)", name, cos_out, cseq[k % 4]);
        end
`endif
        k++;
      end
    end
    en = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_quarter_sweep();
    run_sequence("sweep", 32'h4000_0000, 6, 2047, -6, -2047, 2047, -6, -2047, 6);
  endtask

  task automatic test_wrap();
    run_sequence("wrap", 32'hC000_0000, 6, -2047, -6, 2047, 2047, 6, -2047, -6);
  endtask

  task automatic test_phase_offset();
    fcw = '0; fcw_load = 1'b1; sync_clr = 1'b1; en = 1'b0; phase_off = '0;
    step();
    fcw_load = 1'b0; sync_clr = 1'b0; en = 1'b1; phase_off = 32'h8000_0000;
    repeat (6) step();
    n_checks++;
    if (sin_out !== -12'sd6) begin
      n_fail++;
      $display("FAIL offset_sin: got %0d, required -6", sin_out);
    end
`ifdef NCO_QLUT_COS_EN
    n_checks++;
    if (cos_out !== -12'sd2047) begin
      n_fail++;
      $display("FAIL offset_cos: got %0d, required -2047", cos_out);
    end
`endif
    en = 1'b0; phase_off = '0;
    repeat (3) step();
  endtask

  task automatic test_sync_clr();
    fcw = $urandom(); fcw_load = 1'b1; en = 1'b1; sync_clr = 1'b0; phase_off = '0;
    step();
    fcw_load = 1'b0;
    repeat ($urandom_range(5, 15)) step();
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    repeat (3) step();
    n_checks++;
    if (out_valid !== 1'b1 || sin_out !== 12'sd6) begin
      n_fail++;
      $display("FAIL sync_clr_phase0: valid=%b sin=%0d, required 1 and 6", out_valid, sin_out);
    end
    en = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_en_gaps();
    logic en_hist[$];
    fcw = 32'h0123_4567; fcw_load = 1'b1; sync_clr = 1'b0; en = 1'b0;
    phase_off = 32'h0800_0000;
    step();
    fcw_load = 1'b0;
    for (int i = 0; i < 40; i++) begin
      en = (i < 3) ? 1'(i != 1) : 1'($urandom_range(0, 1));
      // Mid-run fcw change while enabled.
      if (i == 20) begin
        en = 1'b1; fcw = 32'h2000_0001; fcw_load = 1'b1;
      end else begin
        fcw_load = 1'b0;
      end
      en_hist.push_back(en);
      step();
      if (i >= 2) begin
        n_checks++;
        if (out_valid !== en_hist[i - 2]) begin
          n_fail++;
          $display("FAIL en_mirror: step %0d valid=%b, required %b", i, out_valid, en_hist[i - 2]);
        end
      end
    end
    en = 1'b0; fcw_load = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en        = 1'($urandom_range(0, 3) != 0);
      sync_clr  = 1'($urandom_range(0, 19) == 0);
      fcw_load  = 1'($urandom_range(0, 9) == 0);
      fcw       = $urandom();
      phase_off = ($urandom_range(0, 1) != 0) ? $urandom() : '0;
      step();
    end
    en = 1'b0; sync_clr = 1'b0; fcw_load = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset_midstream();
    fcw = 32'h0765_4321; fcw_load = 1'b1; en = 1'b1; phase_off = '0;
    step();
    fcw_load = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_flush: step %0d after release valid=%b, required 0", i, out_valid);
      end
    end
    repeat (6) step();
    en = 1'b0;
  endtask

  task automatic drain();
    en = 1'b0; sync_clr = 1'b0; fcw_load = 1'b0;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d samples outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    for (int k = 0; k < NPT; k++)
      sin_tab[k] = rnd(2047.0 * $sin(2.0 * PI * (real'(k) + 0.5) / real'(NPT)));
    last_sin = '0;
    last_cos = '0;
    test_reset();
    test_quarter_sweep();
    test_phase_offset();
    test_wrap();
    test_sync_clr();
    test_en_gaps();
    test_random();
    test_reset_midstream();
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
